// File: rtl/vsram_write_router.sv
// Write-side front end for the vSRAM bank array: buffers column writes in a
// small FIFO and drains one per clock onto the addressed bank's write port.
module vsramBankPort #(
    parameter int BANK_SEL_W = 2,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 48,
    parameter int BANK_IDX   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [BANK_SEL_W-1:0] bankSel,
    input  logic [ADDR_W-1:0]     colNum,
    input  logic [DATA_W-1:0]     data,
    output logic                  writeEnable,
    output logic [ADDR_W-1:0]     writeAddr,
    output logic [DATA_W-1:0]     writeData
);
    logic hit;
    assign hit = issue && (bankSel == BANK_SEL_W'(BANK_IDX));

    // Idle banks park their address at all ones so a stray enable is harmless.
    always_ff @(posedge clock) begin
        if (reset || !hit) begin
            writeEnable <= 1'b0;
            writeAddr   <= '1;
            writeData   <= '0;
        end else begin
            writeEnable <= 1'b1;
            writeAddr   <= colNum;
            writeData   <= data;
        end
    end
endmodule

module vsram_write_router #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_SEL_W = 2,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 48,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BANK_SEL_W-1:0]         in_bankSel,
    input  logic [ADDR_W-1:0]             in_colNum,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_flush,
    output logic                          out_writeDone,
    output logic                          out_error,
    output logic [CNT_W-1:0]              fifo_count,
    output logic [NUM_BANKS*ADDR_W-1:0]   sram_writeAddr,
    output logic [NUM_BANKS-1:0]          sram_writeEnable,
    output logic [NUM_BANKS*DATA_W-1:0]   sram_writeData
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [BANK_SEL_W-1:0] bankSel;
        logic [ADDR_W-1:0]     colNum;
        logic [DATA_W-1:0]     data;
    } wrReq_t;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    wrReq_t            fifoMem [FIFO_DEPTH];
    wrReq_t            head;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  count;
    state_t            state, stateNext;
    logic              accept, badBank, push, pop, errReg;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = (count < CNT_W'(FIFO_DEPTH)) && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign badBank  = int'(in_bankSel) >= NUM_BANKS;
    assign push     = accept && !badBank;
    assign pop      = (count != '0);
    assign head     = fifoMem[rdPtr];

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr] <= '{bankSel: in_bankSel, colNum: in_colNum, data: in_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            errReg <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            errReg <= accept && badBank;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // An empty FIFO in DRAIN means the last write is already on the bank port.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (in_flush) stateNext = DRAIN;
            DRAIN:   if (count == '0) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign out_writeDone = (state == DONE);
    assign out_error     = errReg;
    assign fifo_count    = count;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
        vsramBankPort #(
            .BANK_SEL_W (BANK_SEL_W),
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W),
            .BANK_IDX   (b)
        ) uPort (
            .clock       (clock),
            .reset       (reset),
            .issue       (pop),
            .bankSel     (head.bankSel),
            .colNum      (head.colNum),
            .data        (head.data),
            .writeEnable (sram_writeEnable[b]),
            .writeAddr   (sram_writeAddr[b*ADDR_W +: ADDR_W]),
            .writeData   (sram_writeData[b*DATA_W +: DATA_W])
        );
    end
endmodule
